// File: rtl/reg_file_nbits.sv
// -----------------------------------------------------------------------------
// reg_file_nbits
//   General-purpose register file feeding the N-bit ALU of the single-cycle
//   datapath. 2^ADDR_W registers of N bits, register 0 reads as zero.
//
// Ports
//   clk_i       rising-edge clock for all state updates
//   rst_n_i     asynchronous active-low reset; clears array and write counter
//   rs_addr_i   read port A address  -> rs_data_o (ALU a_i)
//   rt_addr_i   read port B address  -> rt_data_o (ALU b_i)
//   rd_addr_i   write address
//   wr_en_i     write enable, sampled on rising clk_i
//   wr_data_i   write data
//   dbg_addr_i  debug read address   -> dbg_data_o (array contents, no bypass)
//   wr_count_o  committed non-zero writes since reset, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module reg_file_nbits #(
    parameter int N      = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              wr_en_i,
    input  logic [N-1:0]      wr_data_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [N-1:0]      rs_data_o,
    output logic [N-1:0]      rt_data_o,
    output logic [N-1:0]      dbg_data_o,
    output logic [15:0]       wr_count_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [N-1:0] regs_q [DEPTH];
    logic [N-1:0] regs_d [DEPTH];
    logic [15:0]  wr_count_q;
    logic [15:0]  wr_count_d;
    logic         wr_commit;

    // A write only counts when it targets a real register; writes to r0 vanish.
    assign wr_commit = wr_en_i && (rd_addr_i != '0);

    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (wr_commit) begin
            regs_d[rd_addr_i] = wr_data_i;
            if (wr_count_q != 16'hFFFF) begin
                wr_count_d = wr_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Read ports: r0 is zero, then same-cycle bypass from the write port, then
    // the array. Everything is forced to zero while reset is held so the
    // bypass cannot leak write data through during reset.
    always_comb begin
        rs_data_o = '0;
        if (rst_n_i && (rs_addr_i != '0)) begin
            if (wr_commit && (rd_addr_i == rs_addr_i)) begin
                rs_data_o = wr_data_i;
            end else begin
                rs_data_o = regs_q[rs_addr_i];
            end
        end
    end

    always_comb begin
        rt_data_o = '0;
        if (rst_n_i && (rt_addr_i != '0)) begin
            if (wr_commit && (rd_addr_i == rt_addr_i)) begin
                rt_data_o = wr_data_i;
            end else begin
                rt_data_o = regs_q[rt_addr_i];
            end
        end
    end

    // Debug port shows only what has actually been committed.
    always_comb begin
        dbg_data_o = '0;
        if (rst_n_i && (dbg_addr_i != '0)) begin
            dbg_data_o = regs_q[dbg_addr_i];
        end
    end

    assign wr_count_o = wr_count_q;

endmodule
